// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response bundle for serial_adder.
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, in1, in2, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, in1, in2, Cin,
    output busy, done, Sum, Cout
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder: bit-serial adder, one full-adder cell, LSB first. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  serial_adder_if.slave   sa_if
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_shifted;

  assign w_fa_sum  = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign w_fa_cout = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));

  // DONE accepts a new start just like IDLE, giving back-to-back throughput.
  assign w_accept = sa_if.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_last   = (cnt_q == LAST_BIT);

  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_shifted = w_fa_sum;
    end else begin : g_acc_wn
      assign w_acc_shifted = {w_fa_sum, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sa_if.start) state_d = S_SHIFT;
      S_SHIFT: if (w_last)      state_d = S_DONE;
      S_DONE:  state_d = sa_if.start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sa_if.busy = (state_q == S_SHIFT);
    sa_if.done = (state_q == S_DONE);
  end

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (w_accept) begin
      op_a_d  = sa_if.in1;
      op_b_d  = sa_if.in2;
      carry_d = sa_if.Cin;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_SHIFT) begin
      op_a_d  = op_a_q >> 1;
      op_b_d  = op_b_q >> 1;
      acc_d   = w_acc_shifted;
      carry_d = w_fa_cout;
      cnt_d   = cnt_q + CW'(1);
      // Result registers only move on the final bit, so they hold across operations.
      if (w_last) begin
        sum_d  = w_acc_shifted;
        cout_d = w_fa_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sa_if.Sum  = sum_q;
  assign sa_if.Cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance with queue-based monitor plus a WIDTH=1 instance.
`default_nettype none

module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .sa_if(if8.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .sa_if(if1.slave));

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         errors   = 0;
  int         busy_run = 0;
  logic [7:0] hold_sum  = 8'h00;
  logic       hold_cout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Monitor: pops the expected result on every done pulse, otherwise checks results hold.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        busy_run  = 0;
        hold_sum  = 8'h00;
        hold_cout = 1'b0;
      end else if (if8.done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          chk("done_sum", {24'd0, if8.Sum}, {24'd0, mon_e.sum});
          chk("done_cout", {31'd0, if8.Cout}, {31'd0, mon_e.cout});
          hold_sum  = mon_e.sum;
          hold_cout = mon_e.cout;
        end
        chk("busy_len", busy_run, 8);
        busy_run = 0;
      end else begin
        if (if8.busy) busy_run++;
        chk("hold_result", {23'd0, if8.Cout, if8.Sum}, {23'd0, hold_cout, hold_sum});
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    if8.in1   = a;
    if8.in2   = b;
    if8.Cin   = c;
    if8.start = 1'b1;
    q.push_back(e);
    step();
    if8.start = 1'b0;
    if8.in1   = 8'hEE;
    if8.in2   = 8'hEE;
    if8.Cin   = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!if8.done && n < 40) begin
      step();
      n++;
    end
    if (!if8.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  logic [7:0] va  [5] = '{8'h12, 8'h80, 8'h0F, 8'hC8, 8'h01};
  logic [7:0] vb  [5] = '{8'h34, 8'h80, 8'hF1, 8'h64, 8'h02};
  logic       vc  [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [7:0] ves [5] = '{8'h46, 8'h00, 8'h00, 8'h2D, 8'h04};
  logic       vec [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};

  initial begin
    int n;
    exp_t e;
    if8.start = 1'b0; if8.in1 = 8'h00; if8.in2 = 8'h00; if8.Cin = 1'b0;
    if1.start = 1'b0; if1.in1 = 1'b0;  if1.in2 = 1'b0;  if1.Cin = 1'b0;

    step();
    step();
    chk("rst_busy8", {31'd0, if8.busy}, 0);
    chk("rst_done8", {31'd0, if8.done}, 0);
    chk("rst_sum8",  {24'd0, if8.Sum},  0);
    chk("rst_cout8", {31'd0, if8.Cout}, 0);
    chk("rst_sum1",  {31'd0, if1.Sum},  0);
    chk("rst_cout1", {31'd0, if1.Cout}, 0);
    rst_n = 1'b1;
    step();

    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    wait_done(n);
    step();

    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_done(n);
    step();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    wait_done(n);
    step();

    // Request during busy cycle 3 must be ignored.
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    step();
    step();
    if8.in1 = 8'hAA; if8.in2 = 8'h55; if8.Cin = 1'b0; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    wait_done(n);
    step();

    if8.in1 = va[0]; if8.in2 = vb[0]; if8.Cin = vc[0]; if8.start = 1'b1;
    e.sum = ves[0]; e.cout = vec[0];
    q.push_back(e);
    step();
    for (int k = 0; k < 5; k++) begin
      wait_done(n);
      chk("b2b_gap", n, 8);
      if (k < 4) begin
        if8.in1 = va[k+1]; if8.in2 = vb[k+1]; if8.Cin = vc[k+1];
        e.sum = ves[k+1]; e.cout = vec[k+1];
        q.push_back(e);
      end else begin
        if8.start = 1'b0;
      end
      step();
    end

    // Abort an operation with reset at busy cycle 4.
    if8.in1 = 8'h7F; if8.in2 = 8'h01; if8.Cin = 1'b0; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, if8.busy}, 0);
    chk("abort_done", {31'd0, if8.done}, 0);
    chk("abort_sum",  {24'd0, if8.Sum},  0);
    chk("abort_cout", {31'd0, if8.Cout}, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) step();
    issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
    wait_done(n);
    step();

    if1.in1 = 1'b1; if1.in2 = 1'b1; if1.Cin = 1'b1; if1.start = 1'b1;
    step();
    if1.start = 1'b0; if1.in1 = 1'b0; if1.in2 = 1'b0; if1.Cin = 1'b0;
    chk("w1_busy",  {31'd0, if1.busy}, 1);
    chk("w1_nodone", {31'd0, if1.done}, 0);
    step();
    chk("w1_idle",  {31'd0, if1.busy}, 0);
    chk("w1_done",  {31'd0, if1.done}, 1);
    chk("w1_sum",   {31'd0, if1.Sum},  1);
    chk("w1_cout",  {31'd0, if1.Cout}, 1);
    step();
    chk("w1_pulse", {31'd0, if1.done}, 0);
    chk("w1_hold",  {30'd0, if1.Cout, if1.Sum}, 3);

    step();
    step();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
